// File: rtl/cpu_fetch_pkg.sv
// rtl/cpu_fetch_pkg.sv - shared fetch-stage types, widths and alignment helper
package cpu_fetch_pkg;

    // Default widths, shared with the PC register and decode
    localparam int ADDR_W_DEF = 32;
    localparam int DATA_W_DEF = 32;

    // Instructions are word aligned; any set bit under this mask is a misaligned PC
    localparam logic [1:0] INSTR_ALIGN_MASK = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_HOLD = 2'd2,
        ST_ERR  = 2'd3
    } fetch_state_t;

    function automatic logic pc_is_aligned(input logic [1:0] pc_lo);
        return (pc_lo & INSTR_ALIGN_MASK) == 2'b00;
    endfunction

endpackage

// File: rtl/fetch_watchdog.sv
// rtl/fetch_watchdog.sv - saturating wait-cycle counter for the fetch handshake
module fetch_watchdog #(
    parameter int TIMEOUT = 255
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic count_en,
    output logic expired
);

    localparam int W = $clog2(TIMEOUT + 1);
    localparam logic [W-1:0] LIMIT    = W'(TIMEOUT);
    localparam logic [W-1:0] LIMIT_M1 = W'(TIMEOUT - 1);

    logic [W-1:0] count_q;

    // Count unanswered wait cycles; hold at LIMIT so the counter never wraps
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            count_q <= '0;
        end else if (count_en && (count_q != LIMIT)) begin
            count_q <= count_q + 1'b1;
        end
    end

    // Fires in the wait cycle whose increment would bring the count to TIMEOUT
    assign expired = count_en && (count_q >= LIMIT_M1);

endmodule

// File: rtl/instr_fetch_unit.sv
// rtl/instr_fetch_unit.sv - fetch stage between the PC register and decode
module instr_fetch_unit
    import cpu_fetch_pkg::*;
#(
    parameter int ADDR_W  = ADDR_W_DEF,
    parameter int DATA_W  = DATA_W_DEF,
    parameter int TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] pc,
    output logic              pc_en,
    input  logic              flush,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_ack,
    input  logic [DATA_W-1:0] imem_rdata,
    output logic              instr_valid,
    output logic [DATA_W-1:0] instr,
    output logic [ADDR_W-1:0] instr_pc,
    input  logic              instr_ready,
    output logic              fetch_err
);

    fetch_state_t      state_q, state_d;
    logic              drop_q, drop_d;
    logic              req_q, req_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              valid_q, valid_d;
    logic [DATA_W-1:0] instr_q, instr_d;
    logic [ADDR_W-1:0] ipc_q, ipc_d;
    logic              pc_en_q, pc_en_d;
    logic              err_q, err_d;

    logic              wd_clear;
    logic              wd_count_en;
    logic              wd_expired;

    // Watchdog is zeroed whenever a new request is being launched from IDLE
    assign wd_clear    = (state_q == ST_IDLE);
    assign wd_count_en = (state_q == ST_WAIT) && !imem_ack;

    fetch_watchdog #(
        .TIMEOUT (TIMEOUT)
    ) u_watchdog (
        .clk      (clk),
        .reset    (reset),
        .clear    (wd_clear),
        .count_en (wd_count_en),
        .expired  (wd_expired)
    );

    // Next-state and output-register logic for the fetch FSM
    always_comb begin
        state_d = state_q;
        drop_d  = drop_q;
        req_d   = req_q;
        addr_d  = addr_q;
        valid_d = valid_q;
        instr_d = instr_q;
        ipc_d   = ipc_q;
        pc_en_d = 1'b0;
        err_d   = err_q;

        case (state_q)
            ST_IDLE: begin
                if (!pc_is_aligned(pc[1:0])) begin
                    err_d   = 1'b1;
                    state_d = ST_ERR;
                end else begin
                    addr_d  = pc;
                    req_d   = 1'b1;
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                // The request is never withdrawn; a flush only marks the reply for discard
                if (imem_ack) begin
                    req_d  = 1'b0;
                    drop_d = 1'b0;
                    if (drop_q || flush) begin
                        state_d = ST_IDLE;
                    end else begin
                        instr_d = imem_rdata;
                        ipc_d   = addr_q;
                        valid_d = 1'b1;
                        pc_en_d = 1'b1;
                        state_d = ST_HOLD;
                    end
                end else if (wd_expired) begin
                    req_d   = 1'b0;
                    drop_d  = 1'b0;
                    err_d   = 1'b1;
                    state_d = ST_ERR;
                end else if (flush) begin
                    drop_d = 1'b1;
                end
            end
            ST_HOLD: begin
                // Flush wins over a simultaneous ready: the instruction is not delivered
                if (flush || instr_ready) begin
                    valid_d = 1'b0;
                    state_d = ST_IDLE;
                end
            end
            default: begin
                req_d   = 1'b0;
                valid_d = 1'b0;
                err_d   = 1'b1;
                state_d = ST_ERR;
            end
        endcase
    end

    // State and output registers; reset abandons any outstanding request
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            drop_q  <= 1'b0;
            req_q   <= 1'b0;
            addr_q  <= '0;
            valid_q <= 1'b0;
            instr_q <= '0;
            ipc_q   <= '0;
            pc_en_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            drop_q  <= drop_d;
            req_q   <= req_d;
            addr_q  <= addr_d;
            valid_q <= valid_d;
            instr_q <= instr_d;
            ipc_q   <= ipc_d;
            pc_en_q <= pc_en_d;
            err_q   <= err_d;
        end
    end

    assign pc_en       = pc_en_q;
    assign imem_req    = req_q;
    assign imem_addr   = addr_q;
    assign instr_valid = valid_q;
    assign instr       = instr_q;
    assign instr_pc    = ipc_q;
    assign fetch_err   = err_q;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb/tb_instr_fetch_unit.sv - self-checking bench for instr_fetch_unit
module tb_instr_fetch_unit;

    localparam int TO = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] pc;
    logic        pc_en;
    logic        flush;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        instr_valid;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        instr_ready;
    logic        fetch_err;

    int n_checks = 0;
    int n_fail   = 0;

    instr_fetch_unit #(
        .ADDR_W  (32),
        .DATA_W  (32),
        .TIMEOUT (TO)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .pc          (pc),
        .pc_en       (pc_en),
        .flush       (flush),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ack    (imem_ack),
        .imem_rdata  (imem_rdata),
        .instr_valid (instr_valid),
        .instr       (instr),
        .instr_pc    (instr_pc),
        .instr_ready (instr_ready),
        .fetch_err   (fetch_err)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    logic        p_req, p_ack, p_flush, p_ready, p_valid, p_pcen, last_req;
    logic [31:0] p_addr, p_instr, p_ipc, tgt, exp_pc;
    int          wait_left, rises, pcens, accepts;

    initial begin
        reset = 1'b1; flush = 1'b0; imem_ack = 1'b0; imem_rdata = '0;
        instr_ready = 1'b0; pc = '0;
        step(); step();
        check_eq("rst_ctrl", {imem_req, pc_en, instr_valid, fetch_err}, 4'b0000);
        check_eq("rst_data", {instr, instr_pc, imem_addr}, 96'h0);

        // Basic fetch
        reset = 1'b0; pc = 32'h40;
        step();
        check_eq("basic_req", {imem_req, imem_addr}, {1'b1, 32'h40});
        imem_ack = 1'b1; imem_rdata = 32'h2008_0005;
        step();
        imem_ack = 1'b0; pc = 32'h44;
        check_eq("basic_out", {instr_valid, pc_en, imem_req}, 3'b110);
        check_eq("basic_instr", {instr, instr_pc}, {32'h2008_0005, 32'h40});

        // Backpressure
        for (int i = 0; i < 5; i++) begin
            step();
            check_eq("bp_ctrl", {instr_valid, pc_en, imem_req}, 3'b100);
            check_eq("bp_data", {instr, instr_pc}, {32'h2008_0005, 32'h40});
        end
        instr_ready = 1'b1;
        step();
        instr_ready = 1'b0;
        check_eq("bp_accept", {instr_valid, pc_en}, 2'b00);

        // Flush in WAIT
        step();
        check_eq("fw_req", {imem_req, imem_addr}, {1'b1, 32'h44});
        flush = 1'b1; pc = 32'h100;
        step();
        flush = 1'b0;
        check_eq("fw_hold2", {imem_req, imem_addr, instr_valid}, {1'b1, 32'h44, 1'b0});
        step();
        check_eq("fw_hold3", {imem_req, imem_addr, instr_valid}, {1'b1, 32'h44, 1'b0});
        imem_ack = 1'b1; imem_rdata = 32'hDEAD_BEEF;
        step();
        imem_ack = 1'b0;
        check_eq("fw_drop", {imem_req, instr_valid, pc_en}, 3'b000);
        step();
        check_eq("fw_newreq", {imem_req, imem_addr}, {1'b1, 32'h100});

        // Flush together with ready in HOLD
        imem_ack = 1'b1; imem_rdata = 32'h1111_2222;
        step();
        imem_ack = 1'b0;
        check_eq("fh_valid", {instr_valid, pc_en, instr}, {2'b11, 32'h1111_2222});
        flush = 1'b1; instr_ready = 1'b1; pc = 32'h42;
        step();
        flush = 1'b0; instr_ready = 1'b0;
        check_eq("fh_drop", {instr_valid, pc_en, imem_req}, 3'b000);

        // Misaligned PC
        step();
        check_eq("mis_err", {fetch_err, imem_req}, 2'b10);
        for (int i = 0; i < 3; i++) begin
            flush = 1'b1;
            step();
            check_eq("mis_sticky", {fetch_err, imem_req, instr_valid, pc_en}, 4'b1000);
        end
        flush = 1'b0;

        // Timeout
        reset = 1'b1;
        step();
        check_eq("to_reset", fetch_err, 1'b0);
        reset = 1'b0; pc = 32'h200;
        step();
        check_eq("to_req", {imem_req, imem_addr}, {1'b1, 32'h200});
        for (int i = 0; i < TO - 1; i++) begin
            step();
            check_eq("to_wait", {imem_req, fetch_err}, 2'b10);
        end
        step();
        check_eq("to_expire", {imem_req, fetch_err}, 2'b01);
        step();
        check_eq("to_sticky", {imem_req, fetch_err}, 2'b01);

        // Reset mid-WAIT
        reset = 1'b1;
        step();
        reset = 1'b0; pc = 32'h300;
        step();
        check_eq("rw_req", imem_req, 1'b1);
        reset = 1'b1;
        step();
        check_eq("rw_zero", {imem_req, instr_valid, pc_en, fetch_err, imem_addr}, 36'h0);
        reset = 1'b0;
        step();
        check_eq("rw_resume", {imem_req, imem_addr}, {1'b1, 32'h300});
        imem_ack = 1'b1; imem_rdata = mem_word(32'h300);
        step();
        imem_ack = 1'b0;
        check_eq("rw_instr", {instr_valid, instr, instr_pc}, {1'b1, mem_word(32'h300), 32'h300});
        instr_ready = 1'b1;
        step();
        instr_ready = 1'b0;
        check_eq("rw_accept", instr_valid, 1'b0);

        // Randomised traffic against a transaction-level model
        reset = 1'b1;
        step();
        reset = 1'b0; pc = 32'h1000; exp_pc = 32'h1000;
        last_req = 1'b0; wait_left = 0; rises = 0; pcens = 0; accepts = 0; tgt = '0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            imem_ack = 1'b0; flush = 1'b0;
            if (imem_req) begin
                if (!last_req) wait_left = $urandom_range(0, 2);
                if (wait_left == 0) begin
                    imem_ack = 1'b1;
                    imem_rdata = mem_word(imem_addr);
                end else begin
                    wait_left--;
                end
            end
            if ((imem_req || instr_valid) && ($urandom_range(0, 7) == 0)) begin
                flush = 1'b1;
                tgt = 32'($urandom_range(0, 1023)) << 2;
            end
            instr_ready = 1'($urandom_range(0, 1));
            last_req = imem_req;
            p_req = imem_req; p_addr = imem_addr; p_ack = imem_ack; p_flush = flush;
            p_ready = instr_ready; p_valid = instr_valid; p_pcen = pc_en;
            p_instr = instr; p_ipc = instr_pc;
            step();
            if (p_valid && p_ready && !p_flush) begin
                check_eq("rnd_pc", instr_pc === p_ipc ? p_ipc : instr_pc, exp_pc);
                check_eq("rnd_instr", p_instr, mem_word(exp_pc));
                exp_pc = exp_pc + 32'd4;
                accepts++;
            end
            if (p_flush) begin
                pc = tgt;
                exp_pc = tgt;
            end else if (p_pcen) begin
                pc = pc + 32'd4;
            end
            if (p_req && !p_ack) check_eq("rnd_req_hold", {imem_req, imem_addr}, {1'b1, p_addr});
            if (p_valid && !p_ready && !p_flush)
                check_eq("rnd_stable", {instr_valid, instr, instr_pc}, {1'b1, p_instr, p_ipc});
            if (imem_req && instr_valid) check_eq("rnd_excl", 2'b11, 2'b10);
            if (pc_en) pcens++;
            if (instr_valid && !p_valid) rises++;
            if (fetch_err) check_eq("rnd_no_err", fetch_err, 1'b0);
        end
        check_eq("rnd_pcen_count", pcens, rises);
        check_eq("rnd_progress", accepts > 50, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
